// File: rtl/nios2_oci_trace_pkg.sv
// rtl/nios2_oci_trace_pkg.sv - shared constants and types for the OCI DCT trace packer
// Contents: DCT code values, frame type values, widths, packer state enum
// and the frame assembly helper.
package nios2_oci_trace_pkg;

  localparam int BUF_W = 30;
  localparam int CNT_W = 4;
  localparam int FRM_W = 36;

  localparam logic [1:0] DCT_TAKEN  = 2'b10;
  localparam logic [1:0] DCT_NTAKEN = 2'b01;

  localparam logic [3:0] FRM_DCT = 4'h1;
  localparam logic [3:0] FRM_PC  = 4'h2;

  // Accumulator holds 15 two-bit codes.
  localparam logic [CNT_W-1:0] DCT_SLOTS = 4'd15;

  typedef enum logic {
    ACC     = 1'b0,
    PEND_PC = 1'b1
  } pack_state_e;

  // Frame layout: [35:32] type, [31:30] zero, [29:0] payload.
  function automatic logic [FRM_W-1:0] make_frame(input logic [3:0] ftype,
                                                  input logic [BUF_W-1:0] payload);
    return {ftype, 2'b00, payload};
  endfunction

endpackage

// File: rtl/nios_ii_nios2_qsys_0_nios2_oci_frame_slot.sv
// rtl/nios_ii_nios2_qsys_0_nios2_oci_frame_slot.sv - single-entry valid/ready trace frame register
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   clear            synchronous flush of the held frame
//   load, load_data  write a new frame (caller only loads when not busy)
//   ready            consumer accepts the held frame
//   data, valid      held frame and its presence flag
//   busy             frame held and not being accepted this cycle
module nios_ii_nios2_qsys_0_nios2_oci_frame_slot
  import nios2_oci_trace_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [FRM_W-1:0] load_data,
  input  logic             ready,
  output logic [FRM_W-1:0] data,
  output logic             valid,
  output logic             busy
);

  assign busy = valid && !ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      // Reload in the accept cycle keeps back-to-back frames gapless.
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nios_ii_nios2_qsys_0_nios2_oci_dct_packer.sv
// rtl/nios_ii_nios2_qsys_0_nios2_oci_dct_packer.sv - packs branch DCT codes and jump PCs into trace frames
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   trc_on, trc_clear          trace enable, synchronous clear
//   br_valid, br_taken         retired conditional branch and its outcome
//   jmp_valid, jmp_target      retired indirect jump and its word target
//   dct_buffer, dct_count      current accumulator and number of codes in it
//   itm, itm_valid, itm_ready  36-bit frame output handshake
//   itm_overflow               sticky frame-dropped flag
module nios_ii_nios2_qsys_0_nios2_oci_dct_packer
  import nios2_oci_trace_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trc_on,
  input  logic             trc_clear,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic             jmp_valid,
  input  logic [BUF_W-1:0] jmp_target,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic [FRM_W-1:0] itm,
  output logic             itm_valid,
  input  logic             itm_ready,
  output logic             itm_overflow
);

  pack_state_e      state, state_d;
  logic [BUF_W-1:0] pc_hold, pc_hold_d;
  logic [BUF_W-1:0] nb, buf_d;
  logic [CNT_W-1:0] nc, cnt_d;
  logic             slot_busy, slot_free;
  logic             jv, full;
  logic             load;
  logic [FRM_W-1:0] load_data;
  logic             ovf_set;

  assign slot_free = !slot_busy;
  assign jv        = trc_on && jmp_valid;
  assign full      = trc_on && (nc == DCT_SLOTS);

  // Branch shift happens first; jump/full handling sees the shifted buffer.
  always_comb begin
    nb = dct_buffer;
    nc = dct_count;
    if (trc_on && br_valid) begin
      nb = {(br_taken ? DCT_TAKEN : DCT_NTAKEN), dct_buffer[BUF_W-1:2]};
      nc = dct_count + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ACC;
      pc_hold      <= '0;
      dct_buffer   <= '0;
      dct_count    <= '0;
      itm_overflow <= 1'b0;
    end else if (trc_clear) begin
      state        <= ACC;
      pc_hold      <= '0;
      dct_buffer   <= '0;
      dct_count    <= '0;
      itm_overflow <= 1'b0;
    end else begin
      state        <= state_d;
      pc_hold      <= pc_hold_d;
      dct_buffer   <= buf_d;
      dct_count    <= cnt_d;
      itm_overflow <= itm_overflow | ovf_set;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ACC:     if (jv && slot_free && (nc != '0)) state_d = PEND_PC;
      PEND_PC: if (slot_free) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    buf_d     = nb;
    cnt_d     = nc;
    pc_hold_d = pc_hold;
    load      = 1'b0;
    load_data = '0;
    ovf_set   = 1'b0;
    case (state)
      ACC: begin
        if (jv) begin
          buf_d = '0;
          cnt_d = '0;
          if (slot_free) begin
            load = 1'b1;
            if (nc != '0) begin
              load_data = make_frame(FRM_DCT, nb);
              pc_hold_d = jmp_target;
            end else begin
              load_data = make_frame(FRM_PC, jmp_target);
            end
          end else begin
            ovf_set = 1'b1;
          end
        end else if (full) begin
          buf_d = '0;
          cnt_d = '0;
          if (slot_free) begin
            load      = 1'b1;
            load_data = make_frame(FRM_DCT, nb);
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      PEND_PC: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = make_frame(FRM_PC, pc_hold);
        end
        // The held PC owns the slot, so any new jump or full DCT is lost.
        if (jv || full) begin
          buf_d   = '0;
          cnt_d   = '0;
          ovf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  nios_ii_nios2_qsys_0_nios2_oci_frame_slot u_frame_slot (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (trc_clear),
    .load      (load),
    .load_data (load_data),
    .ready     (itm_ready),
    .data      (itm),
    .valid     (itm_valid),
    .busy      (slot_busy)
  );

endmodule

// File: tb/tb_nios_ii_nios2_qsys_0_nios2_oci_dct_packer.sv
// tb/tb_nios_ii_nios2_qsys_0_nios2_oci_dct_packer.sv - directed self-checking bench for the DCT packer
module tb_nios_ii_nios2_qsys_0_nios2_oci_dct_packer;

  logic        clk;
  logic        reset_n;
  logic        trc_on;
  logic        trc_clear;
  logic        br_valid;
  logic        br_taken;
  logic        jmp_valid;
  logic [29:0] jmp_target;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [35:0] itm;
  logic        itm_valid;
  logic        itm_ready;
  logic        itm_overflow;

  int checks = 0;
  int errors = 0;

  nios_ii_nios2_qsys_0_nios2_oci_dct_packer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .trc_on       (trc_on),
    .trc_clear    (trc_clear),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .itm          (itm),
    .itm_valid    (itm_valid),
    .itm_ready    (itm_ready),
    .itm_overflow (itm_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic taken);
    br_valid = 1'b1;
    br_taken = taken;
    tick();
    br_valid = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic clear_trace();
    trc_clear = 1'b1;
    tick();
    trc_clear = 1'b0;
  endtask

  initial begin
    clk        = 1'b0;
    reset_n    = 1'b0;
    trc_on     = 1'b1;
    trc_clear  = 1'b0;
    br_valid   = 1'b0;
    br_taken   = 1'b0;
    jmp_valid  = 1'b0;
    jmp_target = '0;
    itm_ready  = 1'b1;
    repeat (2) tick();
    chk("rst_itm", itm, 36'h0);
    chk("rst_valid", {35'd0, itm_valid}, 36'd0);
    chk("rst_ovf", {35'd0, itm_overflow}, 36'd0);
    chk("rst_count", {32'd0, dct_count}, 36'd0);
    chk("rst_buf", {6'd0, dct_buffer}, 36'd0);
    reset_n = 1'b1;
    tick();

    // 15 alternating codes starting with taken fill the buffer.
    for (int i = 0; i < 15; i++) branch(i % 2 == 0);
    chk("full_itm", itm, 36'h1_2666_6666);
    chk("full_valid", {35'd0, itm_valid}, 36'd1);
    chk("full_count", {32'd0, dct_count}, 36'd0);
    tick();
    chk("full_drain", {35'd0, itm_valid}, 36'd0);

    // Three taken then a jump: DCT frame followed by the PC frame.
    for (int i = 0; i < 3; i++) branch(1'b1);
    jmp_valid  = 1'b1;
    jmp_target = 30'h0000_1234;
    tick();
    jmp_valid  = 1'b0;
    chk("jmp_dct", itm, 36'h1_2A00_0000);
    chk("jmp_dct_valid", {35'd0, itm_valid}, 36'd1);
    tick();
    chk("jmp_pc", itm, 36'h2_0000_1234);
    chk("jmp_pc_valid", {35'd0, itm_valid}, 36'd1);
    chk("jmp_count", {32'd0, dct_count}, 36'd0);
    tick();
    chk("jmp_drain", {35'd0, itm_valid}, 36'd0);

    // Jump with an empty accumulator gives only a PC frame.
    jmp_valid  = 1'b1;
    jmp_target = 30'h0000_0ABC;
    tick();
    jmp_valid  = 1'b0;
    chk("pc_only", itm, 36'h2_0000_0ABC);
    tick();
    chk("pc_only_drain", {35'd0, itm_valid}, 36'd0);

    // Backpressure: first full frame held, second dropped.
    itm_ready = 1'b0;
    for (int i = 0; i < 15; i++) branch(1'b1);
    chk("bp_first", itm, 36'h1_2AAA_AAAA);
    chk("bp_ovf0", {35'd0, itm_overflow}, 36'd0);
    for (int i = 0; i < 15; i++) branch(1'b0);
    chk("bp_held", itm, 36'h1_2AAA_AAAA);
    chk("bp_held_valid", {35'd0, itm_valid}, 36'd1);
    chk("bp_ovf1", {35'd0, itm_overflow}, 36'd1);
    chk("bp_count", {32'd0, dct_count}, 36'd0);
    clear_trace();
    chk("clr_ovf", {35'd0, itm_overflow}, 36'd0);
    chk("clr_valid", {35'd0, itm_valid}, 36'd0);
    itm_ready = 1'b1;

    // Branch and jump in the same cycle after two not-taken codes.
    branch(1'b0);
    branch(1'b0);
    br_valid   = 1'b1;
    br_taken   = 1'b0;
    jmp_valid  = 1'b1;
    jmp_target = 30'h2000_0001;
    tick();
    br_valid   = 1'b0;
    jmp_valid  = 1'b0;
    chk("bj_dct", itm, 36'h1_1500_0000);
    chk("bj_count", {32'd0, dct_count}, 36'd0);
    tick();
    chk("bj_pc", itm, 36'h2_2000_0001);
    tick();

    // Trace disabled: accumulator holds.
    for (int i = 0; i < 3; i++) branch(1'b1);
    chk("on_count", {32'd0, dct_count}, 36'd3);
    chk("on_buf", {6'd0, dct_buffer}, {6'd0, 30'h2A00_0000});
    trc_on = 1'b0;
    for (int i = 0; i < 4; i++) branch(1'b0);
    chk("off_count", {32'd0, dct_count}, 36'd3);
    chk("off_buf", {6'd0, dct_buffer}, {6'd0, 30'h2A00_0000});
    trc_on = 1'b1;
    clear_trace();

    // Reset with a DCT frame held, a PC pending and seven codes accumulated.
    itm_ready = 1'b0;
    branch(1'b1);
    jmp_valid  = 1'b1;
    jmp_target = 30'h0000_0555;
    tick();
    jmp_valid  = 1'b0;
    for (int i = 0; i < 7; i++) branch(1'b0);
    chk("pre_rst_count", {32'd0, dct_count}, 36'd7);
    chk("pre_rst_valid", {35'd0, itm_valid}, 36'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_itm", itm, 36'h0);
    chk("arst_valid", {35'd0, itm_valid}, 36'd0);
    chk("arst_count", {32'd0, dct_count}, 36'd0);
    chk("arst_buf", {6'd0, dct_buffer}, 36'd0);
    chk("arst_ovf", {35'd0, itm_overflow}, 36'd0);
    reset_n   = 1'b1;
    itm_ready = 1'b1;
    tick();
    chk("arst_pc_lost", {35'd0, itm_valid}, 36'd0);
    chk("arst_ovf_after", {35'd0, itm_overflow}, 36'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_ii_nios2_qsys_0_nios2_oci_dct_packer.md
# nios_ii_nios2_qsys_0_nios2_oci_dct_packer

Instruction-trace packer in the Nios II OCI trace path, directly upstream of the OCI test bench and trace capture. It packs per-branch direct-conditional-trace (DCT) codes into a 30-bit accumulator, published as `dct_buffer`/`dct_count`. It emits fixed 36-bit trace frames over a valid/ready handshake:
- a DCT frame when the accumulator fills or is flushed;
- a PC frame for every indirect jump.

## Interface
- `BUF_W`, 30, accumulator width (15 slots × 2-bit code)
- `CNT_W`, 4, slot-counter width
- `FRM_W`, 36, frame width: [35:32] type, [31:30] zero, [29:0] payload
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `trc_on`  in  1  trace enable; events ignored when low
- `trc_clear`  in  1  synchronous clear of accumulator, pending PC, frame slot, overflow
- `br_valid`  in  1  conditional branch retired this cycle
- `br_taken`  in  1  branch outcome, qualified by `br_valid`
- `jmp_valid`  in  1  indirect jump/exception retired this cycle
- `jmp_target`  in  30  word address of jump target
- `dct_buffer`  out  30  current accumulator
- `dct_count`  out  4  codes in accumulator, 0..15
- `itm`  out  36  trace frame
- `itm_valid`  out  1  frame present
- `itm_ready`  in  1  consumer accepts frame
- `itm_overflow`  out  1  sticky: a frame was dropped

## Operation
- Codes: taken = 2'b10, not-taken = 2'b01, 2'b00 = empty slot.
- Shift rule: `dct_buffer <= {code, dct_buffer[29:2]}`. Newest code sits at [29:28]; unfilled low slots stay 00.
- Frame types: 4'h1 = DCT (payload = buffer), 4'h2 = PC (payload = `jmp_target`).
- Slot free: `!itm_valid || itm_ready`. A loaded frame is held stable until accepted.
- States: `ACC` and `PEND_PC`. `PEND_PC` means a DCT frame is in the slot and `pc_hold` is waiting behind it.
- Per-cycle order:
  - `trc_clear` overrides everything.
  - Otherwise, if `trc_on`, apply a branch shift first, giving next buffer `nb` and next count `nc`.
  - Then evaluate jump or full-buffer handling on `nb`/`nc`.
- `ACC` + `jmp_valid`:
  - slot free and `nc>0`: load DCT(`nb`), `pc_hold<=jmp_target`, go to `PEND_PC`.
  - slot free and `nc==0`: load PC frame directly.
  - slot busy: drop the whole event and set `itm_overflow`.
  - Buffer and count clear in every case.
- `ACC` + `nc==15`, no jump: load DCT(`nb`) if slot free, else drop and set overflow. Buffer and count clear either way.
- `PEND_PC`:
  - When the slot is free, load PC(`pc_hold`) and return to `ACC`. This has priority over a same-cycle full DCT, which is dropped with overflow.
  - Branches keep accumulating.
  - A new `jmp_valid` is dropped with overflow; buffer and count clear.
- `trc_on=0`: buffer, count and state hold. Pending frames still drain.
- `itm_overflow` is cleared only by `trc_clear` or reset.

## Timing
- Reset values: `dct_buffer=0`, `dct_count=0`, `itm=0`, `itm_valid=0`, `itm_overflow=0`, state `ACC`, `pc_hold=0`.
- Event at edge N updates `dct_buffer`/`dct_count` at N+1.
- A frame triggered at edge N is valid at N+1.
- A PC frame behind a DCT frame appears on the first edge after the DCT is accepted. With `itm_ready=1` that is N+2.
- Back-to-back frames are supported: the slot reloads in the same cycle it is accepted.
- Reset asserted mid-operation: all state returns to reset values immediately. A pending frame is lost with no overflow.

## Structure
- Shared package `nios2_oci_trace_pkg`: code constants (`DCT_TAKEN`, `DCT_NTAKEN`), frame type constants, `BUF_W`/`CNT_W`/`FRM_W`, state enum.
- One sub-module: `nios_ii_nios2_qsys_0_nios2_oci_frame_slot`, the single-entry valid/ready output register with a load/busy interface.

## Test plan
- 15 branches alternating T,N,…,T with `itm_ready=1`:
  - cycle after the 15th: `itm=36'h1_2666_6666`, `itm_valid=1`;
  - `dct_count=0`.
- 3 taken, then jump to 30'h0000_1234:
  - `itm=36'h1_2A00_0000`;
  - next cycle `36'h2_0000_1234`;
  - count 0.
- Jump with `dct_count=0`: single frame `36'h2_xxxx` = target; no DCT frame.
- Backpressure: `itm_ready=0`, fill 15 codes, then 15 more:
  - first frame held stable;
  - second frame dropped;
  - `itm_overflow=1`;
  - after `trc_clear`: overflow 0, `itm_valid=0`.
- Branch and jump in the same cycle after 2 N codes: DCT payload holds 3 codes, 32'h1500_0000 (bits [29:24]=010101). The PC frame follows.
- `trc_on=0` with branches: `dct_count` unchanged. Reset pulse with `dct_count=7`, `PEND_PC` set: all outputs 0 immediately.
